hazard_control: RTL

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/hazard_control.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline hazard controller: detects load-use hazards, flushes on taken
//   branches, stalls for multi-cycle multiply/divide operations and parks
//   the pipeline on halt.
//
// Parameters
//   MD_CYCLES    stall length of a multi-cycle multiply/divide (2..15)
//
// Ports
//   clk          clock, state updates on rising edge
//   rst_n        asynchronous active-low reset
//   idReg1/2     source registers of the ID instruction
//   idUsesR0     ID instruction implicitly reads R0
//   exRegDest    destination register of the EX instruction
//   exW          EX write enables: bit0 register file, bit1 R0
//   exMemRead    EX instruction is a load
//   idMulDiv     ID instruction is a multi-cycle multiply/divide
//   branchTaken  branch resolved taken in EX
//   halt         halt decoded in ID
//   pcWrite      PC update enable
//   ifidWrite    IF/ID update enable
//   idexBubble   insert NOP into ID/EX
//   ifidFlush    clear IF/ID
//   idexFlush    clear ID/EX
//   mdStart      pulse: multi-cycle op launched
//   mdDone       pulse: last stall cycle of a multi-cycle op
//   ctrlState    00 RUN, 01 MD_BUSY, 10 HALTED
module hazard_control #(
    parameter int unsigned MD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] idReg1,
    input  logic [3:0] idReg2,
    input  logic       idUsesR0,
    input  logic [3:0] exRegDest,
    input  logic [1:0] exW,
    input  logic       exMemRead,
    input  logic       idMulDiv,
    input  logic       branchTaken,
    input  logic       halt,
    output logic       pcWrite,
    output logic       ifidWrite,
    output logic       idexBubble,
    output logic       ifidFlush,
    output logic       idexFlush,
    output logic       mdStart,
    output logic       mdDone,
    output logic [1:0] ctrlState
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_BUSY = 2'b01,
        HALTED  = 2'b10,
        ILLEGAL = 2'b11
    } ctrlState_t;

    ctrlState_t state, stateNext;
    logic [3:0] count, countNext;
    logic       haltPending, haltPendingNext;
    logic       loadUse;

    assign loadUse = exMemRead &
                     ((exW[0] & ((exRegDest == idReg1) | (exRegDest == idReg2))) |
                      (exW[1] & idUsesR0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            count       <= '0;
            haltPending <= 1'b0;
        end else begin
            state       <= stateNext;
            count       <= countNext;
            haltPending <= haltPendingNext;
        end
    end

    always_comb begin
        stateNext       = state;
        countNext       = count;
        haltPendingNext = haltPending;
        pcWrite         = 1'b1;
        ifidWrite       = 1'b1;
        idexBubble      = 1'b0;
        ifidFlush       = 1'b0;
        idexFlush       = 1'b0;
        mdStart         = 1'b0;
        mdDone          = 1'b0;

        case (state)
            RUN: begin
                if (branchTaken) begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end else if (loadUse) begin
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexBubble = 1'b1;
                end else if (idMulDiv) begin
                    mdStart   = 1'b1;
                    countNext = 4'(MD_CYCLES - 1);
                    stateNext = MD_BUSY;
                end else if (halt) begin
                    stateNext = HALTED;
                end
            end
            MD_BUSY: begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexBubble = 1'b1;
                if (count == 4'd0) begin
                    mdDone = 1'b1;
                    if (haltPending) begin
                        stateNext       = HALTED;
                        haltPendingNext = 1'b0;
                    end else begin
                        stateNext = RUN;
                    end
                end else begin
                    countNext = count - 4'd1;
                    // A halt seen in the final cycle is left in ID and is
                    // picked up normally once back in RUN.
                    if (halt) begin
                        haltPendingNext = 1'b1;
                    end
                end
            end
            HALTED: begin
                pcWrite    = 1'b0;
                ifidWrite  = 1'b0;
                idexBubble = 1'b1;
            end
            default: begin
                stateNext = RUN;
            end
        endcase

        // Reset holds the front end stalled without waiting for a clock edge.
        if (!rst_n) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            ifidFlush  = 1'b0;
            idexFlush  = 1'b0;
            mdStart    = 1'b0;
            mdDone     = 1'b0;
        end
    end

    assign ctrlState = state;

endmodule
